// File: rtl/lbp_port_ctrl.sv
// lbp_port_ctrl: single-port arbiter for the local branch predictor's
// per-bank BHT counter RAM and local-history RAM. It serves three users:
// a clear sweep that re-initialises every row, frontend prediction reads,
// and a small queue of resolved-branch update writes.
module lbp_port_ctrl #(
    parameter int unsigned NR_ROWS    = 64,
    parameter int unsigned NR_BANKS   = 2,
    parameter int unsigned BHT_W      = 2,
    parameter int unsigned LHR_W      = 6,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [BHT_W-1:0] BHT_INIT = BHT_W'(32'd1),
    localparam int unsigned ROW_W  = $clog2(NR_ROWS),
    localparam int unsigned BANK_W = (NR_BANKS > 1) ? $clog2(NR_BANKS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_bp_i,
    input  logic                debug_mode_i,
    input  logic                rd_req_i,
    input  logic [ROW_W-1:0]    rd_row_i,
    output logic                rd_gnt_o,
    input  logic                upd_valid_i,
    input  logic [ROW_W-1:0]    upd_row_i,
    input  logic [BANK_W-1:0]   upd_bank_i,
    input  logic [BHT_W-1:0]    upd_bht_i,
    input  logic [LHR_W-1:0]    upd_lhr_i,
    output logic                ram_en_o,
    output logic                ram_we_o,
    output logic [ROW_W-1:0]    ram_row_o,
    output logic [NR_BANKS-1:0] ram_bank_we_o,
    output logic [BHT_W-1:0]    ram_bht_wdata_o,
    output logic [LHR_W-1:0]    ram_lhr_wdata_o,
    output logic                busy_o,
    output logic [15:0]         drop_cnt_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [BANK_W-1:0] bank;
        logic [BHT_W-1:0]  bht;
        logic [LHR_W-1:0]  lhr;
    } entry_t;

    state_t           state_r;
    logic [ROW_W-1:0] clr_row_r;
    logic             busy_r;
    logic [15:0]      drop_cnt_r;

    entry_t           fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic   fifo_full_s;
    logic   fifo_empty_s;
    entry_t head_s;
    entry_t push_entry_s;
    logic   push_s;
    logic   pop_s;
    logic   drop_s;

    logic                rd_gnt_s;
    logic                ram_en_s;
    logic                ram_we_s;
    logic [ROW_W-1:0]    ram_row_s;
    logic [NR_BANKS-1:0] ram_bank_we_s;
    logic [BHT_W-1:0]    ram_bht_s;
    logic [LHR_W-1:0]    ram_lhr_s;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign fifo_full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_s = (count_r == CNT_W'(0));
    assign head_s       = fifo_mem_r[rd_ptr_r];

    assign push_entry_s = '{row: upd_row_i, bank: upd_bank_i, bht: upd_bht_i, lhr: upd_lhr_i};

    // Updates are only queued in RUN; a flush cycle discards the incoming one.
    assign push_s = upd_valid_i && !debug_mode_i && !flush_bp_i && (state_r == ST_RUN);
    // Lost updates are counted, except those masked by debug mode.
    assign drop_s = upd_valid_i && !debug_mode_i && ((state_r == ST_CLEAR) || flush_bp_i);

    // Port arbitration: sweep in CLEAR; in RUN a full queue beats reads, reads beat a partial queue.
    always_comb begin
        rd_gnt_s      = 1'b0;
        pop_s         = 1'b0;
        ram_en_s      = 1'b0;
        ram_we_s      = 1'b0;
        ram_row_s     = '0;
        ram_bank_we_s = '0;
        ram_bht_s     = '0;
        ram_lhr_s     = '0;
        case (state_r)
            ST_CLEAR: begin
                ram_en_s      = 1'b1;
                ram_we_s      = 1'b1;
                ram_row_s     = clr_row_r;
                ram_bank_we_s = '1;
                ram_bht_s     = BHT_INIT;
                ram_lhr_s     = '0;
            end
            ST_RUN: begin
                if (fifo_full_s || (!rd_req_i && !fifo_empty_s)) begin
                    pop_s         = 1'b1;
                    ram_en_s      = 1'b1;
                    ram_we_s      = 1'b1;
                    ram_row_s     = head_s.row;
                    ram_bank_we_s = NR_BANKS'(1'b1) << head_s.bank;
                    ram_bht_s     = head_s.bht;
                    ram_lhr_s     = head_s.lhr;
                end else if (rd_req_i) begin
                    rd_gnt_s  = 1'b1;
                    ram_en_s  = 1'b1;
                    ram_we_s  = 1'b0;
                    ram_row_s = rd_row_i;
                end else begin
                    ram_en_s = 1'b0;
                end
            end
            default: begin
                ram_en_s = 1'b0;
            end
        endcase
    end

    assign rd_gnt_o        = rd_gnt_s;
    assign ram_en_o        = ram_en_s;
    assign ram_we_o        = ram_we_s;
    assign ram_row_o       = ram_row_s;
    assign ram_bank_we_o   = ram_bank_we_s;
    assign ram_bht_wdata_o = ram_bht_s;
    assign ram_lhr_wdata_o = ram_lhr_s;
    assign busy_o          = busy_r;
    assign drop_cnt_o      = drop_cnt_r;

    // Control FSM: sweep every row after reset or flush, then hand the port to RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_bp_i) begin
            state_r   <= ST_CLEAR;
            clr_row_r <= '0;
            busy_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_row_r == ROW_W'(NR_ROWS - 1)) begin
                        state_r   <= ST_RUN;
                        clr_row_r <= '0;
                        busy_r    <= 1'b0;
                    end else begin
                        state_r   <= ST_CLEAR;
                        clr_row_r <= clr_row_r + ROW_W'(1);
                        busy_r    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_r   <= ST_RUN;
                    clr_row_r <= '0;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_row_r <= '0;
                    busy_r    <= 1'b1;
                end
            endcase
        end
    end

    // Update queue pointers and occupancy; flush discards queued entries silently.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_bp_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_entry_s;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // Saturating count of updates lost to the clear sweep or a flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

endmodule

// File: tb/tb_lbp_port_ctrl.sv
// Directed bench for lbp_port_ctrl with default parameters (64 rows, 2 banks,
// depth-2 update queue). Inputs change 1 ns after the rising edge; outputs
// are sampled on the falling edge.
module tb_lbp_port_ctrl;

    logic       clk;
    logic       rst_i;
    logic       flush_bp_i;
    logic       debug_mode_i;
    logic       rd_req_i;
    logic [5:0] rd_row_i;
    logic       rd_gnt_o;
    logic       upd_valid_i;
    logic [5:0] upd_row_i;
    logic [0:0] upd_bank_i;
    logic [1:0] upd_bht_i;
    logic [5:0] upd_lhr_i;
    logic       ram_en_o;
    logic       ram_we_o;
    logic [5:0] ram_row_o;
    logic [1:0] ram_bank_we_o;
    logic [1:0] ram_bht_wdata_o;
    logic [5:0] ram_lhr_wdata_o;
    logic       busy_o;
    logic [15:0] drop_cnt_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lbp_port_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_bp_i      (flush_bp_i),
        .debug_mode_i    (debug_mode_i),
        .rd_req_i        (rd_req_i),
        .rd_row_i        (rd_row_i),
        .rd_gnt_o        (rd_gnt_o),
        .upd_valid_i     (upd_valid_i),
        .upd_row_i       (upd_row_i),
        .upd_bank_i      (upd_bank_i),
        .upd_bht_i       (upd_bht_i),
        .upd_lhr_i       (upd_lhr_i),
        .ram_en_o        (ram_en_o),
        .ram_we_o        (ram_we_o),
        .ram_row_o       (ram_row_o),
        .ram_bank_we_o   (ram_bank_we_o),
        .ram_bht_wdata_o (ram_bht_wdata_o),
        .ram_lhr_wdata_o (ram_lhr_wdata_o),
        .busy_o          (busy_o),
        .drop_cnt_o      (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // One clear-sweep cycle at the given row.
    task automatic chk_sweep(input int row);
        chk("sweep_busy", 32'(busy_o), 32'd1);
        chk("sweep_en", 32'(ram_en_o), 32'd1);
        chk("sweep_we", 32'(ram_we_o), 32'd1);
        chk("sweep_row", 32'(ram_row_o), 32'(row));
        chk("sweep_bwe", 32'(ram_bank_we_o), 32'h3);
        chk("sweep_bht", 32'(ram_bht_wdata_o), 32'h1);
        chk("sweep_lhr", 32'(ram_lhr_wdata_o), 32'h0);
        chk("sweep_gnt", 32'(rd_gnt_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; flush_bp_i = 1'b0; debug_mode_i = 1'b0;
        rd_req_i = 1'b0; rd_row_i = 6'd0;
        upd_valid_i = 1'b0; upd_row_i = 6'd0; upd_bank_i = 1'b0;
        upd_bht_i = 2'd0; upd_lhr_i = 6'd0;

        // Reset for two edges, then a read request held through the sweep.
        step();
        step();
        rst_i = 1'b0; rd_req_i = 1'b1; rd_row_i = 6'd7;
        for (int i = 0; i < 64; i++) begin
            sample();
            chk_sweep(i);
            if (i == 0) chk("rst_drop", 32'(drop_cnt_o), 32'd0);
            step();
        end
        // Cycle 65: RUN, read granted.
        sample();
        chk("run_busy", 32'(busy_o), 32'd0);
        chk("first_gnt", 32'(rd_gnt_o), 32'd1);
        chk("first_rd_en", 32'(ram_en_o), 32'd1);
        chk("first_rd_we", 32'(ram_we_o), 32'd0);
        chk("first_rd_row", 32'(ram_row_o), 32'd7);
        chk("first_rd_bwe", 32'(ram_bank_we_o), 32'h0);
        step();

        // Read priority: two pushes with reads held, then the full queue wins.
        upd_valid_i = 1'b1; upd_row_i = 6'd5; upd_bank_i = 1'b1; upd_bht_i = 2'b10; upd_lhr_i = 6'h11;
        sample();
        chk("pri_gnt_a", 32'(rd_gnt_o), 32'd1);
        step();
        upd_row_i = 6'd9; upd_bank_i = 1'b0; upd_bht_i = 2'b00; upd_lhr_i = 6'h05;
        sample();
        chk("pri_gnt_b", 32'(rd_gnt_o), 32'd1);
        chk("pri_row_b", 32'(ram_row_o), 32'd7);
        step();
        upd_valid_i = 1'b0;
        sample();
        chk("full_gnt", 32'(rd_gnt_o), 32'd0);
        chk("full_we", 32'(ram_we_o), 32'd1);
        chk("full_row", 32'(ram_row_o), 32'd5);
        chk("full_bwe", 32'(ram_bank_we_o), 32'h2);
        chk("full_bht", 32'(ram_bht_wdata_o), 32'h2);
        chk("full_lhr", 32'(ram_lhr_wdata_o), 32'h11);
        step();
        sample();
        chk("after_full_gnt", 32'(rd_gnt_o), 32'd1);
        chk("after_full_we", 32'(ram_we_o), 32'd0);
        step();
        rd_req_i = 1'b0;
        sample();
        chk("drain_we", 32'(ram_we_o), 32'd1);
        chk("drain_row", 32'(ram_row_o), 32'd9);
        chk("drain_bwe", 32'(ram_bank_we_o), 32'h1);
        chk("drain_lhr", 32'(ram_lhr_wdata_o), 32'h05);
        step();
        sample();
        chk("drain_idle", 32'(ram_en_o), 32'd0);
        step();

        // Idle write: written the cycle after acceptance, not the same cycle.
        upd_valid_i = 1'b1; upd_row_i = 6'd3; upd_bank_i = 1'b0; upd_bht_i = 2'b11; upd_lhr_i = 6'h2A;
        sample();
        chk("idle_same_cycle", 32'(ram_en_o), 32'd0);
        step();
        upd_valid_i = 1'b0;
        sample();
        chk("idle_en", 32'(ram_en_o), 32'd1);
        chk("idle_we", 32'(ram_we_o), 32'd1);
        chk("idle_row", 32'(ram_row_o), 32'd3);
        chk("idle_bwe", 32'(ram_bank_we_o), 32'h1);
        chk("idle_bht", 32'(ram_bht_wdata_o), 32'h3);
        chk("idle_lhr", 32'(ram_lhr_wdata_o), 32'h2A);
        step();
        sample();
        chk("idle_after", 32'(ram_en_o), 32'd0);
        step();

        // Flush from RUN; the flush cycle itself follows RUN rules (idle here).
        flush_bp_i = 1'b1;
        sample();
        chk("flush_run_en", 32'(ram_en_o), 32'd0);
        chk("flush_run_busy", 32'(busy_o), 32'd0);
        step();
        flush_bp_i = 1'b0;
        // Sweep rows 0..30 with three updates dropped; flush again at row 30.
        for (int i = 0; i <= 30; i++) begin
            upd_valid_i = (i >= 1 && i <= 3);
            upd_row_i   = 6'd40;
            flush_bp_i  = (i == 30);
            sample();
            chk("sweep1_row", 32'(ram_row_o), 32'(i));
            chk("sweep1_busy", 32'(busy_o), 32'd1);
            step();
        end
        upd_valid_i = 1'b0; flush_bp_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sample();
            chk_sweep(i);
            if (i == 0) chk("clear_drops", 32'(drop_cnt_o), 32'd3);
            step();
        end
        sample();
        chk("restart_busy_end", 32'(busy_o), 32'd0);
        chk("no_dropped_write", 32'(ram_en_o), 32'd0);
        chk("drop_hold", 32'(drop_cnt_o), 32'd3);
        step();

        // Debug mode: updates ignored and not counted.
        debug_mode_i = 1'b1; upd_valid_i = 1'b1; upd_row_i = 6'd12; upd_bank_i = 1'b1;
        sample();
        chk("dbg_en_a", 32'(ram_en_o), 32'd0);
        step();
        sample();
        chk("dbg_en_b", 32'(ram_en_o), 32'd0);
        step();
        debug_mode_i = 1'b0; upd_valid_i = 1'b0;
        sample();
        chk("dbg_no_write", 32'(ram_en_o), 32'd0);
        chk("dbg_drop", 32'(drop_cnt_o), 32'd3);
        step();

        // Fill the queue under reads, then flush with it full.
        rd_req_i = 1'b1; rd_row_i = 6'd20;
        upd_valid_i = 1'b1; upd_row_i = 6'd40; upd_bank_i = 1'b0; upd_bht_i = 2'b10; upd_lhr_i = 6'h15;
        sample();
        chk("ff_gnt_a", 32'(rd_gnt_o), 32'd1);
        step();
        upd_row_i = 6'd41; upd_bank_i = 1'b1; upd_bht_i = 2'b01; upd_lhr_i = 6'h16;
        sample();
        chk("ff_gnt_b", 32'(rd_gnt_o), 32'd1);
        step();
        upd_valid_i = 1'b0; flush_bp_i = 1'b1;
        sample();
        chk("ff_flush_gnt", 32'(rd_gnt_o), 32'd0);
        chk("ff_flush_row", 32'(ram_row_o), 32'd40);
        chk("ff_flush_bwe", 32'(ram_bank_we_o), 32'h1);
        step();
        flush_bp_i = 1'b0; rd_req_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sample();
            chk_sweep(i);
            step();
        end
        sample();
        chk("ff_discarded", 32'(ram_en_o), 32'd0);
        chk("ff_drop", 32'(drop_cnt_o), 32'd3);
        step();

        // Reset and flush together: reset wins and clears the drop count.
        rst_i = 1'b1; flush_bp_i = 1'b1;
        step();
        rst_i = 1'b0; flush_bp_i = 1'b0;
        sample();
        chk("rstflush_drop", 32'(drop_cnt_o), 32'd0);
        chk("rstflush_busy", 32'(busy_o), 32'd1);
        chk("rstflush_row", 32'(ram_row_o), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
